// File: rtl/riscv_bp_resolve_if.sv
// Signal bundle between the pipeline (ID/EX stages) and the branch-resolution unit.
// The master side is the pipeline; the slave side is riscv_bp_resolve.
interface riscv_bp_resolve_if #(
    parameter int XLEN           = 32,
    parameter int BP_GLOBAL_BITS = 2
);
    logic                      id_bp_valid;
    logic                      id_stall;
    logic [1:0]                id_bp_predict;
    logic                      ex_branch_valid;
    logic                      ex_btaken;
    logic [XLEN-1:0]           ex_pc;
    logic                      flush;
    logic                      fifo_full;
    logic                      ex_mispredict;
    logic [BP_GLOBAL_BITS-1:0] bu_bp_history;
    logic [1:0]                bu_bp_predict;
    logic                      bu_bp_btaken;
    logic                      bu_bp_update;
    logic [XLEN-1:0]           bu_bp_pc;

    modport master (
        output id_bp_valid, id_stall, id_bp_predict,
        output ex_branch_valid, ex_btaken, ex_pc, flush,
        input  fifo_full, ex_mispredict,
        input  bu_bp_history, bu_bp_predict, bu_bp_btaken, bu_bp_update, bu_bp_pc
    );

    modport slave (
        input  id_bp_valid, id_stall, id_bp_predict,
        input  ex_branch_valid, ex_btaken, ex_pc, flush,
        output fifo_full, ex_mispredict,
        output bu_bp_history, bu_bp_predict, bu_bp_btaken, bu_bp_update, bu_bp_pc
    );
endinterface

// File: rtl/riscv_bp_resolve.sv
// Branch resolution for the correlating predictor: ID->EX prediction FIFO, mispredict flag,
// predictor write-back and global history. Optional counters via RISCV_BP_STATS_EN.
module riscv_bp_resolve #(
    parameter int XLEN           = 32,
    parameter int BP_GLOBAL_BITS = 2,
    parameter int PIPE_DEPTH     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    riscv_bp_resolve_if.slave    bp
`ifdef RISCV_BP_STATS_EN
    ,
    output logic [31:0]          stat_branches_o,
    output logic [31:0]          stat_mispredicts_o
`endif
);

    localparam int PW = $clog2(PIPE_DEPTH);
    localparam int CW = PW + 1;

    logic [1:0]                mem_q [PIPE_DEPTH];
    logic [PW-1:0]             wptr_q, rptr_q;
    logic [CW-1:0]             count_q, count_d;
    logic                      full_q;
    logic                      empty, push, pop, kill, mispredict;
    logic [1:0]                head;

    logic                      upd_q;
    logic [1:0]                predict_q;
    logic                      btaken_q;
    logic [XLEN-1:0]           pc_q;
    logic [BP_GLOBAL_BITS-1:0] hist_q, hist_shift;

    // An empty pop resolves against strong not-taken and leaves the pointers alone.
    // A pop frees the head slot, so a push is still accepted when full in that cycle.
    always_comb begin
        empty      = (count_q == '0);
        pop        = bp.ex_branch_valid & ~empty;
        head       = empty ? 2'b00 : mem_q[rptr_q];
        mispredict = bp.ex_branch_valid & (head[1] ^ bp.ex_btaken);
        kill       = bp.flush | mispredict;
        push       = bp.id_bp_valid & ~bp.id_stall & (~full_q | pop) & ~kill;
    end

    always_comb begin
        count_d = count_q;
        if (kill)
            count_d = '0;
        else if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            for (int i = 0; i < PIPE_DEPTH; i++)
                mem_q[i] <= 2'b00;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == CW'(PIPE_DEPTH));
            if (push)
                mem_q[wptr_q] <= bp.id_bp_predict;
            // Wrong-path entries are discarded by restarting both pointers.
            if (kill) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push)
                    wptr_q <= wptr_q + PW'(1);
                if (pop)
                    rptr_q <= rptr_q + PW'(1);
            end
        end
    end

    generate
        if (BP_GLOBAL_BITS == 1) begin : g_hist_1
            assign hist_shift = btaken_q;
        end else begin : g_hist_n
            assign hist_shift = {hist_q[BP_GLOBAL_BITS-2:0], btaken_q};
        end
    endgenerate

    // History only advances after the predictor has been written at the old history index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            upd_q     <= 1'b0;
            predict_q <= 2'b00;
            btaken_q  <= 1'b0;
            pc_q      <= '0;
            hist_q    <= '0;
        end else begin
            upd_q <= bp.ex_branch_valid;
            if (bp.ex_branch_valid) begin
                predict_q <= head;
                btaken_q  <= bp.ex_btaken;
                pc_q      <= bp.ex_pc;
            end
            if (upd_q)
                hist_q <= hist_shift;
        end
    end

    assign bp.fifo_full     = full_q;
    assign bp.ex_mispredict = mispredict;
    assign bp.bu_bp_history = hist_q;
    assign bp.bu_bp_predict = predict_q;
    assign bp.bu_bp_btaken  = btaken_q;
    assign bp.bu_bp_update  = upd_q;
    assign bp.bu_bp_pc      = pc_q;

`ifdef RISCV_BP_STATS_EN
    logic [31:0] stat_br_q, stat_mp_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (upd_q && stat_br_q != 32'hFFFF_FFFF)
                stat_br_q <= stat_br_q + 32'd1;
            if (mispredict && stat_mp_q != 32'hFFFF_FFFF)
                stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign stat_branches_o    = stat_br_q;
    assign stat_mispredicts_o = stat_mp_q;
`endif

endmodule

// File: tb/tb_riscv_bp_resolve.sv
// Directed bench for riscv_bp_resolve: FIFO, mispredict/kill, update timing, history, reset.
module tb_riscv_bp_resolve;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   errors = 0;
    int   checks = 0;

    riscv_bp_resolve_if #(.XLEN(32), .BP_GLOBAL_BITS(2)) bp ();

`ifdef RISCV_BP_STATS_EN
    logic [31:0] stat_b, stat_m;
`endif

    riscv_bp_resolve #(.XLEN(32), .BP_GLOBAL_BITS(2), .PIPE_DEPTH(2)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bp     (bp)
`ifdef RISCV_BP_STATS_EN
        ,
        .stat_branches_o    (stat_b),
        .stat_mispredicts_o (stat_m)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        bp.id_bp_valid     = 1'b0;
        bp.id_stall        = 1'b0;
        bp.id_bp_predict   = 2'b00;
        bp.ex_branch_valid = 1'b0;
        bp.ex_btaken       = 1'b0;
        bp.ex_pc           = 32'h0;
        bp.flush           = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_update",  32'(bp.bu_bp_update), 0);
        chk("rst_full",    32'(bp.fifo_full), 0);
        chk("rst_history", 32'(bp.bu_bp_history), 0);
        chk("rst_predict", 32'(bp.bu_bp_predict), 0);
        chk("rst_btaken",  32'(bp.bu_bp_btaken), 0);
        chk("rst_pc",      bp.bu_bp_pc, 0);
        rst_ni = 1'b1;
        step();

        // 1: predict 11, resolve taken
        bp.id_bp_valid = 1'b1; bp.id_bp_predict = 2'b11;
        step();
        bp.id_bp_valid = 1'b0;
        bp.ex_branch_valid = 1'b1; bp.ex_btaken = 1'b1; bp.ex_pc = 32'h100;
        #1;
        chk("t1_mispredict", 32'(bp.ex_mispredict), 0);
        step();
        bp.ex_branch_valid = 1'b0;
        chk("t1_update",  32'(bp.bu_bp_update), 1);
        chk("t1_predict", 32'(bp.bu_bp_predict), 3);
        chk("t1_btaken",  32'(bp.bu_bp_btaken), 1);
        chk("t1_history", 32'(bp.bu_bp_history), 0);
        chk("t1_pc",      bp.bu_bp_pc, 32'h100);
        step();
        chk("t1_update_off",   32'(bp.bu_bp_update), 0);
        chk("t1_history_next", 32'(bp.bu_bp_history), 1);

        // 2: mispredict kills queued entry and same-cycle push
        bp.id_bp_valid = 1'b1; bp.id_bp_predict = 2'b01;
        step();
        bp.id_bp_predict = 2'b11;
        step();
        chk("t2_full", 32'(bp.fifo_full), 1);
        bp.id_bp_predict = 2'b10;
        bp.ex_branch_valid = 1'b1; bp.ex_btaken = 1'b1; bp.ex_pc = 32'h200;
        #1;
        chk("t2_mispredict", 32'(bp.ex_mispredict), 1);
        step();
        bp.id_bp_valid = 1'b0;
        bp.ex_btaken = 1'b0; bp.ex_pc = 32'h204;
        #1;
        chk("t2_full_after_kill", 32'(bp.fifo_full), 0);
        chk("t2_update",  32'(bp.bu_bp_update), 1);
        chk("t2_predict", 32'(bp.bu_bp_predict), 1);
        chk("t2_history", 32'(bp.bu_bp_history), 1);
        chk("t2_empty_head", 32'(bp.ex_mispredict), 0);
        step();
        bp.ex_branch_valid = 1'b0;
        chk("t2_uf_update",  32'(bp.bu_bp_update), 1);
        chk("t2_uf_predict", 32'(bp.bu_bp_predict), 0);
        chk("t2_uf_btaken",  32'(bp.bu_bp_btaken), 0);
        chk("t2_uf_history", 32'(bp.bu_bp_history), 3);
        step();
        chk("t2_update_off",   32'(bp.bu_bp_update), 0);
        chk("t2_history_next", 32'(bp.bu_bp_history), 2);

        // 3: fill, drop on full, push+pop while full across wrap
        bp.id_bp_valid = 1'b1; bp.id_bp_predict = 2'b11;
        step();
        chk("t3_full_1", 32'(bp.fifo_full), 0);
        bp.id_bp_predict = 2'b01;
        step();
        chk("t3_full_2", 32'(bp.fifo_full), 1);
        bp.id_bp_predict = 2'b00;
        step();
        chk("t3_full_drop", 32'(bp.fifo_full), 1);
        bp.id_bp_predict = 2'b10;
        bp.ex_branch_valid = 1'b1; bp.ex_btaken = 1'b1; bp.ex_pc = 32'h300;
        #1;
        chk("t3_pop_a_mp", 32'(bp.ex_mispredict), 0);
        step();
        bp.id_bp_valid = 1'b0;
        bp.ex_btaken = 1'b0; bp.ex_pc = 32'h304;
        #1;
        chk("t3_full_pushpop", 32'(bp.fifo_full), 1);
        chk("t3_upd_a",        32'(bp.bu_bp_update), 1);
        chk("t3_predict_a",    32'(bp.bu_bp_predict), 3);
        chk("t3_pop_b_mp",     32'(bp.ex_mispredict), 0);
        step();
        bp.ex_btaken = 1'b1; bp.ex_pc = 32'h308;
        #1;
        chk("t3_full_b",    32'(bp.fifo_full), 0);
        chk("t3_predict_b", 32'(bp.bu_bp_predict), 1);
        chk("t3_btaken_b",  32'(bp.bu_bp_btaken), 0);
        chk("t3_history_b", 32'(bp.bu_bp_history), 1);
        chk("t3_pop_d_mp",  32'(bp.ex_mispredict), 0);
        step();
        bp.ex_branch_valid = 1'b0;
        chk("t3_upd_d",     32'(bp.bu_bp_update), 1);
        chk("t3_predict_d", 32'(bp.bu_bp_predict), 2);
        chk("t3_pc_d",      bp.bu_bp_pc, 32'h308);
        step();
        chk("t3_update_off", 32'(bp.bu_bp_update), 0);
        chk("t3_history",    32'(bp.bu_bp_history), 1);

        // 4: underflow resolve taken
        bp.ex_branch_valid = 1'b1; bp.ex_btaken = 1'b1; bp.ex_pc = 32'h400;
        #1;
        chk("t4_mispredict", 32'(bp.ex_mispredict), 1);
        step();
        bp.ex_branch_valid = 1'b0;
        chk("t4_update",  32'(bp.bu_bp_update), 1);
        chk("t4_predict", 32'(bp.bu_bp_predict), 0);
        chk("t4_btaken",  32'(bp.bu_bp_btaken), 1);
        chk("t4_pc",      bp.bu_bp_pc, 32'h400);
        step();
        chk("t4_history", 32'(bp.bu_bp_history), 3);

        // 6: reset during an update strobe
        bp.ex_branch_valid = 1'b1; bp.ex_btaken = 1'b1; bp.ex_pc = 32'h500;
        step();
        bp.ex_branch_valid = 1'b0;
        chk("t6_update_pre", 32'(bp.bu_bp_update), 1);
        rst_ni = 1'b0;
        #1;
        chk("t6_update_rst",  32'(bp.bu_bp_update), 0);
        chk("t6_history_rst", 32'(bp.bu_bp_history), 0);
        chk("t6_pc_rst",      bp.bu_bp_pc, 0);
        chk("t6_predict_rst", 32'(bp.bu_bp_predict), 0);
`ifdef RISCV_BP_STATS_EN
        chk("t6_stat_br", stat_b, 0);
        chk("t6_stat_mp", stat_m, 0);
`endif
        #2;
        rst_ni = 1'b1;
        step();
        chk("t6_no_strobe_1", 32'(bp.bu_bp_update), 0);
        step();
        chk("t6_no_strobe_2", 32'(bp.bu_bp_update), 0);

        // 5: four taken resolves back-to-back from history 00
        bp.ex_branch_valid = 1'b1; bp.ex_btaken = 1'b1; bp.ex_pc = 32'h600;
        step();
        chk("t5_upd_1",  32'(bp.bu_bp_update), 1);
        chk("t5_hist_1", 32'(bp.bu_bp_history), 0);
        step();
        chk("t5_upd_2",  32'(bp.bu_bp_update), 1);
        chk("t5_hist_2", 32'(bp.bu_bp_history), 1);
        step();
        chk("t5_upd_3",  32'(bp.bu_bp_update), 1);
        chk("t5_hist_3", 32'(bp.bu_bp_history), 3);
        step();
        bp.ex_branch_valid = 1'b0;
        chk("t5_upd_4",  32'(bp.bu_bp_update), 1);
        chk("t5_hist_4", 32'(bp.bu_bp_history), 3);
        step();
        chk("t5_upd_end",  32'(bp.bu_bp_update), 0);
        chk("t5_hist_end", 32'(bp.bu_bp_history), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
